// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run/step controller: state encoding and default widths.
package cpu_run_ctrl_pkg;

   localparam int DIV_W_DEF = 4;
   localparam int CYC_W_DEF = 24;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/cpu_clk_div.sv
// Divided CPU clock: toggles every div_q+1 enabled cycles, parked low whenever disabled or loading.
module cpu_clk_div
   import cpu_run_ctrl_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [DIV_W-1:0] div_q,
   output logic             cpu_clk,
   output logic             rise,
   output logic             fall
);

   logic [DIV_W-1:0] dcnt_q, dcnt_d;
   logic             clk_q, clk_d;
   logic             tick;

   always_comb begin
      tick   = en && !load && (dcnt_q == div_q);
      dcnt_d = dcnt_q;
      clk_d  = clk_q;
      if (load || !en) begin
         dcnt_d = '0;
         clk_d  = 1'b0;
      end else if (tick) begin
         dcnt_d = '0;
         clk_d  = !clk_q;
      end else begin
         dcnt_d = dcnt_q + 1'b1;
      end
      // Pulses announce the toggle that happens at the coming edge.
      rise = tick && !clk_q;
      fall = tick && clk_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dcnt_q <= '0;
         clk_q  <= 1'b0;
      end else begin
         dcnt_q <= dcnt_d;
         clk_q  <= clk_d;
      end
   end

   assign cpu_clk = clk_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: launches measured runs or single steps of the divided CPU clock and gates the event counter.
module cpu_run_ctrl
   import cpu_run_ctrl_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF,
   parameter int CYC_W = CYC_W_DEF
) (
   input  logic             clk_mem,
   input  logic             rst,
   input  logic             start,
   input  logic             step,
   input  logic             abort,
   input  logic [DIV_W-1:0] div_i,
   input  logic [CYC_W-1:0] budget_i,
   output logic             cpu_clk,
   output logic             cnt_clr,
   output logic             cnt_en,
   output logic             busy,
   output logic             done,
   output logic [CYC_W-1:0] cyc_o
);

   state_e           state_q, state_d;
   logic             start_q, step_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CYC_W-1:0] bud_q, bud_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [CYC_W-1:0] runc_q, runc_d;
   logic             start_edge, step_edge, run_or_drain, abort_low;
   logic             div_en, div_load, rise, fall;

   cpu_clk_div #(.DIV_W(DIV_W)) u_div (
      .clk     (clk_mem),
      .rst     (rst),
      .en      (div_en),
      .load    (div_load),
      .div_q   (div_q),
      .cpu_clk (cpu_clk),
      .rise    (rise),
      .fall    (fall)
   );

   always_comb begin
      start_edge   = start && !start_q;
      step_edge    = step && !step_q;
      run_or_drain = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      // An abort with the clock low halts at once, so the pending rise must be suppressed.
      abort_low    = (state_q == ST_RUN) && abort && !cpu_clk;
      div_en       = run_or_drain && !abort_low;
      div_load     = (state_q == ST_CLEAR) ||
                     (((state_q == ST_IDLE) || (state_q == ST_DONE)) && step_edge && !start_edge);

      state_d = state_q;
      div_d   = div_q;
      bud_d   = bud_q;
      cyc_d   = cyc_q;
      runc_d  = runc_q;
      if (rise) begin
         cyc_d  = cyc_q + 1'b1;
         runc_d = runc_q + 1'b1;
      end

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_edge) begin
               state_d = ST_CLEAR;
            end else if (step_edge) begin
               state_d = ST_RUN;
               div_d   = div_i;
               bud_d   = CYC_W'(1);
               runc_d  = '0;
            end
         end
         ST_CLEAR: begin
            state_d = ST_RUN;
            div_d   = div_i;
            bud_d   = budget_i;
            cyc_d   = '0;
            runc_d  = '0;
         end
         ST_RUN: begin
            // runc counts rises of this run only, so a step keeps cyc_o yet still stops after one cycle.
            if (abort_low) begin
               state_d = ST_DONE;
            end else if (abort) begin
               state_d = fall ? ST_DONE : ST_DRAIN;
            end else if (rise && (bud_q != '0) && ((runc_q + 1'b1) == bud_q)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fall) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_mem) begin
      if (rst) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         step_q  <= 1'b0;
         div_q   <= '0;
         bud_q   <= '0;
         cyc_q   <= '0;
         runc_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         step_q  <= step;
         div_q   <= div_d;
         bud_q   <= bud_d;
         cyc_q   <= cyc_d;
         runc_q  <= runc_d;
      end
   end

   assign cnt_clr = (state_q == ST_CLEAR);
   assign cnt_en  = run_or_drain;
   assign busy    = (state_q == ST_CLEAR) || run_or_drain;
   assign done    = (state_q == ST_DONE);
   assign cyc_o   = cyc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized runs against an arithmetic run model.
module tb_cpu_run_ctrl;

   localparam int DIV_W = 4;
   localparam int CYC_W = 24;

   logic             clk_mem = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             step = 1'b0;
   logic             abort = 1'b0;
   logic [DIV_W-1:0] div_i = '0;
   logic [CYC_W-1:0] budget_i = '0;
   logic             cpu_clk, cnt_clr, cnt_en, busy, done;
   logic [CYC_W-1:0] cyc_o;

   int          n_checks = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   int          mcyc = 0;

   cpu_run_ctrl #(.DIV_W(DIV_W), .CYC_W(CYC_W)) dut (
      .clk_mem  (clk_mem),
      .rst      (rst),
      .start    (start),
      .step     (step),
      .abort    (abort),
      .div_i    (div_i),
      .budget_i (budget_i),
      .cpu_clk  (cpu_clk),
      .cnt_clr  (cnt_clr),
      .cnt_en   (cnt_en),
      .busy     (busy),
      .done     (done),
      .cyc_o    (cyc_o)
   );

   // clock / reset
   always #5 clk_mem = ~clk_mem;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_mem);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      check("rst_cpu_clk", cpu_clk, 0);
      check("rst_cnt_clr", cnt_clr, 0);
      check("rst_cnt_en", cnt_en, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cyc_o", cyc_o, 0);
      rst = 1'b0;
      mcyc = 0;
   endtask

   // Reference model: mode 0 start, 1 step, 2 start with abort at RUN-cycle k, 3 start+step together.
   task automatic model_run(input int mode, input int d, input int n, input int k);
      int clr_n, en_n, rises, phase;
      if (mode == 1) begin
         clr_n = 0;
         en_n  = 2 * (d + 1);
         rises = 1;
         mcyc  = (mcyc + 1) % (1 << CYC_W);
      end else if (mode == 2) begin
         clr_n = 1;
         phase = k / (d + 1);
         rises = (phase + 1) / 2;
         en_n  = (phase % 2 == 1) ? (phase + 1) * (d + 1) : k + 1;
         mcyc  = rises;
      end else begin
         clr_n = 1;
         en_n  = 2 * n * (d + 1);
         rises = n;
         mcyc  = n;
      end
      exp_q.push_back(clr_n);
      exp_q.push_back(en_n);
      exp_q.push_back(rises);
      exp_q.push_back(0);
      exp_q.push_back(0);
      exp_q.push_back(mcyc);
   endtask

   task automatic wait_done(input int d, input bit hold, input int abort_k,
                            output int clr_n, output int en_n, output int rises,
                            output int bad_ph, output int bad_fl, output bit to);
      bit cur_lvl;
      int cur_len, en_idx;
      bit first;
      clr_n = 0; en_n = 0; rises = 0; bad_ph = 0; bad_fl = 0; to = 1'b1;
      cur_lvl = 1'b0; cur_len = 0; en_idx = 0; first = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         tick();
         if (first) begin
            step = 1'b0;
            if (!hold) start = 1'b0;
            first = 1'b0;
         end
         abort = 1'b0;
         if (busy !== (cnt_clr | cnt_en)) bad_fl++;
         if (!cnt_en && cpu_clk !== 1'b0) bad_fl++;
         if (done === busy) bad_fl++;
         if (cnt_clr) clr_n++;
         if (cnt_en) begin
            en_n++;
            div_i    = DIV_W'($urandom);
            budget_i = CYC_W'($urandom_range(1, 3));
            if (cpu_clk === cur_lvl) cur_len++;
            else begin
               if (cur_len != d + 1) bad_ph++;
               if (cpu_clk) rises++;
               cur_lvl = cpu_clk;
               cur_len = 1;
            end
            if (en_idx == abort_k) abort = 1'b1;
            en_idx++;
         end
         if (done === 1'b1) begin
            if (cur_lvl && cur_len != d + 1) bad_ph++;
            to = 1'b0;
            break;
         end
      end
      abort = 1'b0;
   endtask

   task automatic do_run(input int mode, input int d, input int n, input int k, input bit hold);
      int clr_n, en_n, rises, bad_ph, bad_fl;
      bit to;
      div_i    = DIV_W'(d);
      budget_i = (mode == 1) ? CYC_W'($urandom_range(0, 9)) : CYC_W'(n);
      model_run(mode, d, n, k);
      start = (mode != 1);
      step  = (mode == 1) || (mode == 3);
      wait_done(d, hold, (mode == 2) ? k : -1, clr_n, en_n, rises, bad_ph, bad_fl, to);
      check("timeout", to, 0);
      check("cnt_clr_cycles", clr_n, exp_q.pop_front());
      check("cnt_en_cycles", en_n, exp_q.pop_front());
      check("cpu_rises", rises, exp_q.pop_front());
      check("phase_len_errs", bad_ph, exp_q.pop_front());
      check("flag_errs", bad_fl, exp_q.pop_front());
      check("cyc_o", cyc_o, exp_q.pop_front());
   endtask

   initial begin
      int seen, viol;
      repeat (3) tick();
      do_reset();
      tick();

      do_run(0, 15, 3, -1, 1'b0);
      do_run(1, 1, 0, -1, 1'b0);
      do_run(2, 0, 0, 7, 1'b0);

      // start and step together from IDLE
      do_reset();
      do_run(3, 2, 2, -1, 1'b0);

      // reset in DRAIN with the CPU clock high
      div_i = 4'd3; budget_i = 24'd1; start = 1'b1;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         start = 1'b0;
         if (cpu_clk === 1'b1) begin
            seen = 1;
            break;
         end
      end
      check("drain_reached", seen, 1);
      do_reset();
      do_run(0, $urandom_range(0, 5), $urandom_range(1, 3), -1, 1'b0);

      // start held through DONE must not relaunch
      do_run(0, 1, 2, -1, 1'b1);
      viol = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (busy !== 1'b0 || done !== 1'b1 || cnt_clr !== 1'b0) viol++;
      end
      check("held_start_no_rerun", viol, 0);
      check("held_start_cyc_o", cyc_o, mcyc);
      start = 1'b0;
      tick();
      do_run(0, 0, 1, -1, 1'b0);

      for (int i = 0; i < 8; i++) begin
         int mode, d, n, k;
         mode = $urandom_range(0, 3);
         d    = $urandom_range(0, 7);
         n    = (mode == 2) ? 0 : $urandom_range(1, 4);
         k    = $urandom_range(0, 40);
         do_run(mode, d, n, k, 1'b0);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
